// File: rtl/systolic_pkg.sv
// Shared sizes, matrix/stream/result types and state encodings for the
// systolic array feeder.
package systolic_pkg;

    localparam int unsigned N      = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned ACC_W  = 16;
    localparam int unsigned S_LEN  = 2 * N - 1;

    typedef logic [N-1:0][N-1:0][DATA_W-1:0] matrix_t;
    typedef logic [N-1:0][S_LEN-1:0][DATA_W-1:0] stream_t;
    typedef logic [N-1:0][N-1:0][ACC_W-1:0] result_t;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        CAPTURE,
        HOLD
    } state_t;

    typedef enum logic {
        SKEW_ROW,
        SKEW_COL
    } skew_t;

endpackage

// File: rtl/systolic_feeder_if.sv
// Job (A/B in) and result (C out) handshake bundle between a host and the feeder.
interface systolic_feeder_if;
    import systolic_pkg::*;

    matrix_t i_a;
    matrix_t i_b;
    logic    i_valid;
    logic    o_ready;
    result_t o_c;
    logic    o_valid;
    logic    i_ready;

    modport master (
        output i_a, i_b, i_valid, i_ready,
        input  o_ready, o_c, o_valid
    );

    modport slave (
        input  i_a, i_b, i_valid, i_ready,
        output o_ready, o_c, o_valid
    );

endinterface

// File: rtl/skew_shifter.sv
// Loads one matrix as N diagonally skewed streams (row or column flavour)
// and shifts every stream one element toward index 0 when enabled.
module skew_shifter
    import systolic_pkg::*;
#(
    parameter skew_t SKEW = SKEW_ROW
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    load,
    input  logic    shift,
    input  matrix_t mat,
    output stream_t streams
);

    stream_t skewed;

    for (genvar i = 0; i < N; i++) begin : g_lane
        // Lane i carries its data delayed by i slots; slots outside the window are zero.
        for (genvar k = 0; k < S_LEN; k++) begin : g_elem
            if (k >= i && k - i < N) begin : g_data
                if (SKEW == SKEW_ROW) begin : g_row
                    assign skewed[i][k] = mat[i][k - i];
                end else begin : g_col
                    assign skewed[i][k] = mat[k - i][i];
                end
            end else begin : g_zero
                assign skewed[i][k] = '0;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                streams[i] <= '0;
            end else if (load) begin
                streams[i] <= skewed[i];
            end else if (shift) begin
                streams[i] <= streams[i] >> DATA_W;
            end
        end
    end

endmodule

// File: rtl/systolic_feeder.sv
// Sequencer for the 4x4 systolic array: accepts A/B, streams skewed data,
// pulses the array clear, runs it, then captures and holds the result.
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int unsigned DRAIN = N
) (
    input  logic             i_clk,
    input  logic             i_srst,
    systolic_feeder_if.slave bus,
    output stream_t          o_row,
    output stream_t          o_col,
    output logic             o_doProcess,
    output logic             o_arrayRst,
    input  result_t          i_c
);

    localparam int unsigned      RUN_CYCLES = S_LEN + DRAIN;
    localparam int unsigned      CNT_W      = $clog2(RUN_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_RUN   = CNT_W'(RUN_CYCLES - 1);

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] count;
    logic             load;
    logic             shift;
    logic             ready_q;
    logic             valid_q;
    logic             do_process_q;
    logic             array_rst_q;
    result_t          c_q;

    assign shift = (state == RUN);

    skew_shifter #(.SKEW(SKEW_ROW)) u_row (
        .clk     (i_clk),
        .rst     (i_srst),
        .load    (load),
        .shift   (shift),
        .mat     (bus.i_a),
        .streams (o_row)
    );

    skew_shifter #(.SKEW(SKEW_COL)) u_col (
        .clk     (i_clk),
        .rst     (i_srst),
        .load    (load),
        .shift   (shift),
        .mat     (bus.i_b),
        .streams (o_col)
    );

    always_comb begin
        state_n = state;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.i_valid && ready_q) begin
                    state_n = CLEAR;
                    load    = 1'b1;
                end
            end
            CLEAR:   state_n = RUN;
            RUN:     if (count == LAST_RUN) state_n = CAPTURE;
            CAPTURE: state_n = HOLD;
            HOLD:    if (bus.i_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Handshake and array controls are flops fed by the next state, so they
    // line up with the state they belong to and never glitch from i_valid.
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            state        <= IDLE;
            count        <= '0;
            ready_q      <= 1'b1;
            valid_q      <= 1'b0;
            do_process_q <= 1'b0;
            array_rst_q  <= 1'b0;
            c_q          <= '0;
        end else begin
            state        <= state_n;
            count        <= (state == RUN) ? count + CNT_W'(1) : '0;
            ready_q      <= (state_n == IDLE);
            valid_q      <= (state_n == HOLD);
            do_process_q <= (state_n == RUN);
            array_rst_q  <= (state_n == CLEAR);
            if (state == CAPTURE) begin
                c_q <= i_c;
            end
        end
    end

    assign bus.o_ready = ready_q;
    assign bus.o_valid = valid_q;
    assign bus.o_c     = c_q;
    assign o_doProcess = do_process_q;
    assign o_arrayRst  = array_rst_q;

endmodule
